dbg_reg_access: RTL
===================

DBG_REG_ACCESS -- requirements
Module: dbg_reg_access

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 4, meaning the number of dropped write attempts before the block reports an error.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, 1 bit: host command valid.
REQ-005 SHALL have port req_ready_o, output, 1 bit: block accepts a command.
REQ-006 SHALL have port req_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr_i, input, 5 bits (RegAddrBus): target GPR.
REQ-008 SHALL have port req_data_i, input, 32 bits (RegBus): write data.
REQ-009 SHALL have port resp_valid_o, output, 1 bit: response valid.
REQ-010 SHALL have port resp_ready_i, input, 1 bit: host accepts the response.
REQ-011 SHALL have port resp_data_o, output, 32 bits: read data, or write read-back data.
REQ-012 SHALL have port resp_err_o, output, 1 bit: write abandoned after MAX_RETRY drops.
REQ-013 SHALL have port ex_we_i, input, 1 bit: core write-back enable, used to detect collisions.
REQ-014 SHALL have port ex_waddr_i, input, 5 bits: core write-back address.
REQ-015 SHALL have port jtag_we_o, output, 1 bit: register-file debug write enable.
REQ-016 SHALL have port jtag_addr_o, output, 5 bits: register-file debug read/write address.
REQ-017 SHALL have port jtag_data_o, output, 32 bits: register-file debug write data.
REQ-018 SHALL have port jtag_data_i, input, 32 bits: register-file debug read data (combinational, 0 for x0).

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, CHECK, RESP.
REQ-020 SHALL assert req_ready_o only in IDLE, and SHALL accept a command on req_valid_i && req_ready_o, latching we, addr and data.
REQ-021 SHALL transition IDLE->READ on an accepted read, and IDLE->WRITE on an accepted write with addr != 0.
REQ-022 SHALL transition IDLE->RESP on an accepted write to x0: no jtag_we_o pulse, resp_data_o = 0, resp_err_o = 0.
REQ-023 SHALL, in READ, drive jtag_addr_o = latched addr, capture jtag_data_i into resp_data_o, and go to RESP (resp_valid_o two cycles after acceptance).
REQ-024 SHALL assert jtag_we_o only in WRITE, decoded from state, with jtag_addr_o / jtag_data_o = latched values.
REQ-025 SHALL treat a WRITE cycle with ex_we_i = 1 and ex_waddr_i != 0 as dropped (the register file prioritises the core write, regardless of address).
REQ-026 SHALL, on a dropped write, increment the retry counter and stay in WRITE; on the MAX_RETRY-th drop it SHALL go to RESP with resp_err_o = 1 and resp_data_o = 0.
REQ-027 SHALL, on an undropped write, go to CHECK; CHECK SHALL capture jtag_data_i into resp_data_o with resp_err_o = 0 and go to RESP (resp_valid_o three cycles after acceptance).
REQ-028 SHALL NOT flag a CHECK value that differs from the written data as an error; the read-back value is reported as-is.
REQ-029 SHALL hold resp_valid_o, resp_data_o and resp_err_o stable in RESP until resp_ready_i = 1, then go to IDLE; a new command is accepted no earlier than the following cycle.
REQ-030 SHALL clear the retry counter on every command acceptance; the counter width SHALL be clog2(MAX_RETRY+1).
REQ-031 SHALL drive jtag_addr_o = latched addr in all states, and jtag_data_o = latched data.

Reset
REQ-032 SHALL, on rst = 1 and at any time (including mid-write), asynchronously force state IDLE and set to 0: jtag_we_o, resp_valid_o, resp_err_o, resp_data_o, the latched addr/data, and the retry counter.
REQ-033 SHALL have req_ready_o = 1 on the first cycle after reset release.

Structure
REQ-034 SHALL take RegAddrBus, RegBus, ZeroReg, ZeroWord and WriteEnable from the shared defines.v; FSM state encodings and MAX_RETRY stay local.
REQ-035 SHALL be a single flat module, with no sub-module.

Verification
REQ-036 Read x5 = 0x1234_5678 -> resp_valid_o at cycle 2 with resp_data_o = 0x1234_5678, resp_err_o = 0, jtag_we_o never high.
REQ-037 Write x7 = 0xDEAD_BEEF, ex_we_i = 0 -> one-cycle jtag_we_o pulse at cycle 1; resp at cycle 3 with data 0xDEAD_BEEF, err 0.
REQ-038 Write x7 = 0xA5A5_A5A5 with ex_we_i = 1 (ex_waddr_i = 3) in the first WRITE cycle only -> two jtag_we_o cycles; resp at cycle 4 with data 0xA5A5_A5A5, err 0.
REQ-039 Write x9 with ex_we_i = 1 (ex_waddr_i = 9) held continuously, MAX_RETRY = 4 -> exactly 4 jtag_we_o cycles, then resp_err_o = 1, resp_data_o = 0.
REQ-040 Write x0 = 0xFFFF_FFFF -> no jtag_we_o pulse; resp at cycle 1 with data 0, err 0.
REQ-041 Assert rst mid-WRITE, with resp_ready_i held 0 in a prior RESP -> jtag_we_o drops immediately, state IDLE, req_ready_o = 1 after release.

Source files
------------

// File: rtl/dbg_reg_access_pkg.sv
// Shared register-file widths and constants used by the debug register access block.
package dbg_reg_access_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG     = '0;
    localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
    localparam logic                  WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/dbg_reg_access.sv
// Debug-port access to the GPR file: reads, and writes that retry while the
// core's own write-back owns the register-file write port.
module dbg_reg_access
    import dbg_reg_access_pkg::*;
#(
    parameter int MAX_RETRY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [REG_ADDR_W-1:0] req_addr_i,
    input  logic [REG_W-1:0]      req_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [REG_W-1:0]      resp_data_o,
    output logic                  resp_err_o,
    input  logic                  ex_we_i,
    input  logic [REG_ADDR_W-1:0] ex_waddr_i,
    output logic                  jtag_we_o,
    output logic [REG_ADDR_W-1:0] jtag_addr_o,
    output logic [REG_W-1:0]      jtag_data_o,
    input  logic [REG_W-1:0]      jtag_data_i
);

    localparam int CNT_W = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] LAST_RETRY = CNT_W'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        CHECK,
        RESP
    } state_t;

    state_t                state;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [REG_W-1:0]      data_q;
    logic [CNT_W-1:0]      retry_cnt;
    logic                  dropped;

    // The register file lets any core write-back to a real GPR win the port.
    assign dropped     = ex_we_i && (ex_waddr_i != ZERO_REG);
    assign req_ready_o = (state == IDLE);
    assign jtag_we_o   = (state == WRITE) ? WRITE_ENABLE : ~WRITE_ENABLE;
    assign jtag_addr_o = addr_q;
    assign jtag_data_o = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= ZERO_REG;
            data_q       <= ZERO_WORD;
            retry_cnt    <= '0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= ZERO_WORD;
            resp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q    <= req_addr_i;
                        data_q    <= req_data_i;
                        retry_cnt <= '0;
                        if (!req_we_i) begin
                            state <= READ;
                        end else if (req_addr_i != ZERO_REG) begin
                            state <= WRITE;
                        end else begin
                            // x0 is hardwired: acknowledge immediately without touching the file.
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_data_o  <= ZERO_WORD;
                            resp_err_o   <= 1'b0;
                        end
                    end
                end
                READ: begin
                    state        <= RESP;
                    resp_valid_o <= 1'b1;
                    resp_data_o  <= jtag_data_i;
                    resp_err_o   <= 1'b0;
                end
                WRITE: begin
                    if (dropped) begin
                        retry_cnt <= retry_cnt + CNT_W'(1);
                        if (retry_cnt == LAST_RETRY) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_data_o  <= ZERO_WORD;
                            resp_err_o   <= 1'b1;
                        end
                    end else begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    // Read-back is reported verbatim; a mismatch is not treated as an error.
                    state        <= RESP;
                    resp_valid_o <= 1'b1;
                    resp_data_o  <= jtag_data_i;
                    resp_err_o   <= 1'b0;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
